sm3_msg_expand_stream: RTL
==========================

Name: sm3_msg_expand_stream

Overview:
Iterative, parametrised SM3 message-expansion engine for the SM3 accelerator datapath. It takes one 512-bit padded block and streams W_j and W'_j (j = 0..63) to the compression round logic, LANES words per beat, under a valid/ready handshake. It keeps a registered 16-word sliding window and generates new words on the fly, so it needs no 68-word combinational array. It supports backpressure and explicit start and last signalling.

Parameters:
LANES, 4, words emitted per beat; legal values 1, 2, 4, 8; 64 must be divisible by LANES.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  load block and begin expansion; sampled only in IDLE
block  in  512  padded message block; word0 = block[511:480], word15 = block[31:0]
busy  out  1  high in RUN
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
j_out  out  7  index j of lane 0 in the current beat
w_out  out  32*LANES  W[j+i] on bits [32i+31:32i]
wp_out  out  32*LANES  W'[j+i] = W[j+i] ^ W[j+i+4] on bits [32i+31:32i]
out_last  out  1  current beat is the final one (j_out = 64-LANES)

Behaviour:
- Reset: async to IDLE. Window registers = 0, j = 0. busy, out_valid, out_last = 0. j_out, w_out, wp_out = 0.
- States: IDLE and RUN.
- IDLE:
  - out_valid = 0; w_out, wp_out, j_out, out_last are forced to 0.
  - start=1 at clock edge t: window[0..15] <= block words 0..15, j <= 0, go to RUN. out_valid = 1 from cycle t+1 (latency 1).
- RUN:
  - out_valid = 1; outputs are driven from the registered window and j.
  - Lane i: W = window[i], W' = window[i] ^ window[i+4].
- Handshake (out_valid & out_ready):
  - If j = 64-LANES: go to IDLE. out_last is high during this beat.
  - Otherwise: j += LANES; window shifts down by LANES; window[16-LANES..15] <= generated words.
- No handshake: all outputs hold stable. out_ready may toggle freely.
- Word generation (combinational chain of LANES words, computed from the window), for k = j+16+m, m = 0..LANES-1:
  - t = W[k-16] ^ W[k-9] ^ ROTL(W[k-3], 15)
  - P1(t) = t ^ ROTL(t, 15) ^ ROTL(t, 23)
  - W[k] = P1(t) ^ ROTL(W[k-13], 7) ^ W[k-6]
  - For m >= 3, W[k-3] is itself a generated word in the same chain.
  - Words with index > 67 may be generated but never reach the outputs.
- Arithmetic: all operations are 32-bit, no carries. ROTL is a left rotate.
- Beats per block: 64/LANES. j_out steps 0, LANES, 2·LANES, …, 64-LANES.
- start while in RUN: ignored; the block input is not re-sampled.
- start in the same cycle as the last handshake: ignored, because the state is still RUN. The FSM enters IDLE, and a start in the next cycle is accepted.
- Reset during RUN: outputs go to 0 immediately (async). The partial stream is discarded; the next start restarts at j = 0.
- block may change after the start cycle without affecting the current stream.

Test Plan:
- LANES=4, block = "abc" padded (61626380, 00000000 x14, 00000018), out_ready=1:
  - 16 consecutive beats.
  - Beat 0: w lane0 = 61626380, wp lane0 = 61626380.
  - Beat 4 (j=16): w = 9092e200, 00000000, 000c0606, 719c70ed.
  - Beat 5: w lane1 = 8001801f.
  - out_last only at j=60; busy drops the cycle after.
- Same stimulus with random out_ready backpressure: the output sequence is identical to the previous test, and w_out, wp_out, j_out are stable while out_ready=0.
- LANES=1, "abc" block: 64 beats, j_out increments by 1, beat 16 w_out = 9092e200, beat 19 w_out = 719c70ed, out_last at j=63.
- Start pulses mid-stream and in the same cycle as the last handshake:
  - Both are ignored; the stream is unchanged.
  - A start one cycle after return to IDLE begins a new stream with j_out = 0.
- Assert rst low while j_out = 32:
  - out_valid, busy, w_out, wp_out go to 0 without a clock edge.
  - After release, a new start streams from j = 0 with correct values.
- All-zero block, LANES=2: 32 beats with all w_out/wp_out = 0 and out_last on beat 31 (j=62).

Source files
------------

// File: rtl/sm3_msg_expand_stream_if.sv
// Stream bundle between the SM3 message-expansion engine and the round logic.
// The engine sits on the master side; the block source and round logic sit on the slave side.
interface sm3_msg_expand_stream_if #(
  parameter int LANES = 4
);
  logic                  start;
  logic [511:0]          block;
  logic                  busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [6:0]            j_out;
  logic [32*LANES-1:0]   w_out;
  logic [32*LANES-1:0]   wp_out;
  logic                  out_last;

  modport master (
    input  start, block, out_ready,
    output busy, out_valid, j_out, w_out, wp_out, out_last
  );

  modport slave (
    output start, block, out_ready,
    input  busy, out_valid, j_out, w_out, wp_out, out_last
  );
endinterface

// File: rtl/sm3_msg_expand_stream.sv
// SM3 message expansion: streams W_j / W'_j, LANES words per beat, from a 16-word sliding window.
//
// state | meaning
// IDLE  | waiting for start; all outputs held at 0
// RUN   | window valid, beat presented at j; shifts by LANES on each accepted beat
module sm3_msg_expand_stream #(
  parameter int LANES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  sm3_msg_expand_stream_if.master      bus
);

  localparam logic [6:0] STEP   = 7'(LANES);
  localparam logic [6:0] LAST_J = 7'(64 - LANES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // window word i lives at win[32*i +: 32]; word 0 is the oldest (W[j])
  logic [511:0]                 win;
  logic [511:0]                 win_load;
  logic [6:0]                   j;
  logic [32*LANES-1:0]          gen;
  logic [32*(16+LANES)-1:0]     ext;
  logic                         hs;
  logic                         at_last;

  logic                         busy_q;
  logic                         valid_c;
  logic                         last_c;
  logic [6:0]                   j_c;
  logic [32*LANES-1:0]          w_c;
  logic [32*LANES-1:0]          wp_c;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  // Chain of LANES new words; later words reuse earlier ones for W[k-3] and W[k-6].
  function automatic logic [32*LANES-1:0] expand(input logic [511:0] w);
    logic [31:0]         e [16+LANES];
    logic [31:0]         t;
    logic [32*LANES-1:0] r;
    for (int i = 0; i < 16; i++) begin
      e[i] = w[32*i +: 32];
    end
    for (int m = 0; m < LANES; m++) begin
      t          = e[m] ^ e[m+7] ^ rotl(e[m+13], 15);
      e[m+16]    = p1(t) ^ rotl(e[m+3], 7) ^ e[m+10];
      r[32*m +: 32] = e[m+16];
    end
    return r;
  endfunction

  always_comb begin
    win_load = '0;
    for (int i = 0; i < 16; i++) begin
      win_load[32*i +: 32] = bus.block[511-32*i -: 32];
    end
  end

  assign gen     = expand(win);
  assign ext     = {gen, win};
  assign hs      = (state == RUN) && bus.out_ready;
  assign at_last = (j == LAST_J);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (hs && at_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win <= '0;
      j   <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        win <= win_load;
        j   <= '0;
      end
    end else if (hs && !at_last) begin
      win <= ext[32*(16+LANES)-1 : 32*LANES];
      j   <= j + STEP;
    end
  end

  always_comb begin
    busy_q  = 1'b0;
    valid_c = 1'b0;
    last_c  = 1'b0;
    j_c     = '0;
    w_c     = '0;
    wp_c    = '0;
    if (state == RUN) begin
      busy_q  = 1'b1;
      valid_c = 1'b1;
      last_c  = at_last;
      j_c     = j;
      for (int i = 0; i < LANES; i++) begin
        w_c[32*i +: 32]  = win[32*i +: 32];
        wp_c[32*i +: 32] = win[32*i +: 32] ^ win[32*(i+4) +: 32];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = valid_c;
  assign bus.out_last  = last_c;
  assign bus.j_out     = j_c;
  assign bus.w_out     = w_c;
  assign bus.wp_out    = wp_c;

endmodule
